// File: rtl/tree_layer1_reader_pkg.sv
// Shared tree-sensing definitions: reader FSM encoding, default
// geometry, layer-1 RAM constants used by both layer-1 writer and reader.
package tree_layer1_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_t;

    localparam int DEF_NUM_COUNTER = 10;
    localparam int DEF_NUM_SLICE   = 3;
    localparam int DEF_DIVISOR     = 3;
    localparam int DEF_ADDR_W      = 10;

    localparam int L1_RAM_WIDTH = 8;
    localparam int L1_RAM_DEPTH = 1024;
    localparam int OUT_CNT_W    = 32;

    localparam int TOTAL = DEF_NUM_COUNTER * DEF_NUM_SLICE;

    function automatic int calc_total(input int nc, input int ns);
        return nc * ns;
    endfunction

endpackage

// File: rtl/tree_skid_fifo.sv
// Two-entry fall-through FIFO: an empty FIFO presents write data directly.
// Ports: Wr_en/Wr_data in, Rd_valid/Rd_data/Rd_ready out side, Count occupancy.
module tree_skid_fifo #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         Wr_en,
    input  logic [W-1:0] Wr_data,
    input  logic         Rd_ready,
    output logic         Rd_valid,
    output logic [W-1:0] Rd_data,
    output logic [1:0]   Count
);

    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count_q;
    logic         empty;
    logic         push;
    logic         pop;

    assign empty = (count_q == 2'd0);
    // A write into an empty FIFO that is consumed at once is never stored.
    assign push  = Wr_en && !(empty && Rd_ready);
    assign pop   = !empty && Rd_ready;

    assign Rd_valid = !empty || Wr_en;
    assign Count    = count_q;

    always_comb begin
        Rd_data = '0;
        if (!empty)
            Rd_data = mem[rd_ptr];
        else if (Wr_en)
            Rd_data = Wr_data;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < 2; i++)
                mem[i] <= '0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= Wr_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/tree_layer1_reader.sv
// Reads the whole layer-1 RAM (port B) and streams {index, counter} entries.
// Ports: Start/Busy/Done control, Ram_rden/Ram_addr/Ram_q, Out_* handshake.
module tree_layer1_reader
    import tree_layer1_reader_pkg::*;
#(
    parameter int NUM_COUNTER = DEF_NUM_COUNTER,
    parameter int NUM_SLICE   = DEF_NUM_SLICE,
    parameter int DIVISOR     = DEF_DIVISOR,
    parameter int ADDR_W      = DEF_ADDR_W
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    Start,
    output logic                    Busy,
    output logic                    Done,
    output logic                    Ram_rden,
    output logic [ADDR_W-1:0]       Ram_addr,
    input  logic [L1_RAM_WIDTH-1:0] Ram_q,
    output logic                    Out_valid,
    input  logic                    Out_ready,
    output logic [ADDR_W-1:0]       Out_index,
    output logic [OUT_CNT_W-1:0]    Out_counter
);

    localparam int TOT = calc_total(NUM_COUNTER, NUM_SLICE);
    localparam int CW  = $clog2(TOT + 1);
    localparam int FW  = ADDR_W + DIVISOR;

    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(TOT - 1);
    localparam logic [CW-1:0]     TOT_C = CW'(TOT);

    rd_state_t          state;
    rd_state_t          state_nx;
    logic [ADDR_W-1:0]  ptr;
    logic [ADDR_W-1:0]  rd_addr_q;
    logic               inflight;
    logic [CW-1:0]      xfer_cnt;
    logic [CW-1:0]      xfer_nx;
    logic [1:0]         fifo_count;
    logic [1:0]         occ;
    logic               issue;
    logic               start_go;
    logic               xfer;
    logic               fifo_valid;
    logic [FW-1:0]      fifo_wdata;
    logic [FW-1:0]      fifo_rdata;
    logic [L1_RAM_WIDTH-1:0] unused_q;

    assign unused_q = Ram_q;

    // Buffered plus in-flight entries never exceed the two FIFO slots.
    assign occ     = fifo_count + 2'(inflight);
    assign xfer    = fifo_valid && Out_ready;
    assign xfer_nx = xfer_cnt + CW'(xfer);

    always_comb begin
        state_nx = state;
        Done     = 1'b0;
        start_go = 1'b0;
        issue    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (Start) begin
                    start_go = 1'b1;
                    state_nx = ST_READ;
                end
            end
            ST_READ: begin
                if (occ < 2'd2) begin
                    issue = 1'b1;
                    if (ptr == LAST)
                        state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Every entry handed over implies FIFO and RAM pipe are empty.
                if (xfer_nx == TOT_C)
                    state_nx = ST_DONE;
            end
            ST_DONE: begin
                Done     = 1'b1;
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ptr       <= '0;
            rd_addr_q <= '0;
            inflight  <= 1'b0;
            xfer_cnt  <= '0;
        end else begin
            inflight <= issue;
            if (start_go) begin
                ptr      <= '0;
                xfer_cnt <= '0;
            end else begin
                if (issue) begin
                    ptr       <= ptr + 1'b1;
                    rd_addr_q <= ptr;
                end
                xfer_cnt <= xfer_nx;
            end
        end
    end

    assign Busy     = (state != ST_IDLE);
    assign Ram_rden = issue;
    assign Ram_addr = issue ? ptr : '0;

    assign fifo_wdata = {rd_addr_q, Ram_q[DIVISOR-1:0]};

    tree_skid_fifo #(
        .W(FW)
    ) u_fifo (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Wr_en    (inflight),
        .Wr_data  (fifo_wdata),
        .Rd_ready (Out_ready),
        .Rd_valid (fifo_valid),
        .Rd_data  (fifo_rdata),
        .Count    (fifo_count)
    );

    assign Out_valid   = fifo_valid;
    assign Out_index   = fifo_rdata[FW-1:DIVISOR];
    assign Out_counter = {{(OUT_CNT_W-DIVISOR){1'b0}}, fifo_rdata[DIVISOR-1:0]};

endmodule

// File: doc/tree_layer1_reader.md
TREE_LAYER1_READER -- requirements
Module: tree_layer1_reader

Interface
REQ-001 NUM_COUNTER, 10, counters per slice; TOTAL = NUM_COUNTER*NUM_SLICE SHALL satisfy 1 <= TOTAL <= 1024.
REQ-002 NUM_SLICE, 3, number of slices.
REQ-003 DIVISOR, 3, valid low bits per layer-1 entry; range 1..8.
REQ-004 ADDR_W, 10, RAM address width.
REQ-005 Clk  in  1  clock; all logic on rising edge.
REQ-006 Reset_n  in  1  reset, asynchronous, active-low.
REQ-007 Start  in  1  one-cycle request to read back the whole layer-1 RAM.
REQ-008 Busy  out  1  high from the cycle after an accepted Start until the Done cycle inclusive.
REQ-009 Done  out  1  one-cycle pulse after the last output transfer.
REQ-010 Ram_rden  out  1  layer-1 RAM read enable.
REQ-011 Ram_addr  out  ADDR_W  layer-1 RAM read address.
REQ-012 Ram_q  in  8  RAM read data; valid exactly 1 cycle after Ram_rden.
REQ-013 Out_valid  out  1  output entry available.
REQ-014 Out_ready  in  1  consumer accepts the entry; transfer = Out_valid & Out_ready.
REQ-015 Out_index  out  ADDR_W  RAM address of the presented entry.
REQ-016 Out_counter  out  32  reconstructed layer-1 value: {zeros, Ram_q[DIVISOR-1:0]}.

Function
REQ-017 FSM states: IDLE, READ, DRAIN, DONE.
REQ-018 IDLE: Start=1 -> READ and read pointer cleared to 0; Start is ignored in all other states.
REQ-019 READ: issue Ram_rden=1 with Ram_addr=pointer only when buffer occupancy plus in-flight reads is < 2; pointer increments on each issued read.
REQ-020 After the read at address TOTAL-1 is issued -> DRAIN; no further reads are issued.
REQ-021 DRAIN: when no read is in flight, the buffer is empty, and the transfer count equals TOTAL -> DONE.
REQ-022 DONE: Done=1 for exactly one cycle, then -> IDLE.
REQ-023 Output buffer: 2-entry FIFO of {index, counter}; read data is written in the cycle Ram_q is valid; the FIFO never overflows.
REQ-024 Entries are output in strictly ascending index order, 0..TOTAL-1, each exactly once.
REQ-025 Out_counter bits [31:DIVISOR] SHALL be 0; Ram_q bits [7:DIVISOR] are discarded.
REQ-026 Out_valid, Out_index and Out_counter remain stable while Out_valid=1 and Out_ready=0.
REQ-027 Throughput: with Out_ready held high, one transfer per cycle after a 2-cycle initial latency (first Out_valid 2 cycles after Start).
REQ-028 A simultaneous FIFO write and transfer in the same cycle keeps occupancy unchanged.
REQ-029 Ram_rden=0 and Ram_addr=0 whenever no read is being issued.
REQ-030 TOTAL=1 degenerate case: a single read, then DRAIN, then DONE.

Reset
REQ-031 Reset_n=0 forces IDLE immediately, clears pointer, counters, FIFO, and in-flight flag; any run in progress is abandoned and a discarded read result is never output.
REQ-032 Outputs while in reset: Busy=0, Done=0, Ram_rden=0, Ram_addr=0, Out_valid=0, Out_index=0, Out_counter=0.
REQ-033 After release, no read is issued until a new Start.

Structure
REQ-034 The FSM state encoding, TOTAL, and the default DIVISOR/ADDR_W SHALL be placed in a shared tree-sensing package, alongside the layer constants used by the layer-1 writer.
REQ-035 The 2-entry output FIFO SHALL be a sub-module, tree_skid_fifo, parameterised on data width.
REQ-036 RAM is external; this block connects only to the read port (port B) of the 8x1024 layer-1 RAM.

Verification
REQ-037 RAM preloaded with mem[i]=i+5 (i=0..29), Start, Out_ready=1 -> 30 transfers, index i with counter (i+5)&7, first Out_valid at cycle 2, Done 1 cycle after transfer 29.
REQ-038 Same preload, Out_ready toggled 1/0 every cycle -> identical 30-entry sequence, no loss or duplication, at most 2 reads outstanding, output stable while stalled.
REQ-039 mem[3]=8'hFF, DIVISOR=3 -> Out_counter for index 3 = 32'h7; with DIVISOR=8 -> 32'hFF.
REQ-040 Start pulsed again at transfer 10 -> ignored; still exactly 30 transfers and one Done.
REQ-041 Reset_n asserted at transfer 15, released, then Start -> all outputs 0 during reset; the new run delivers indices 0..29 with no stale entries.
REQ-042 NUM_COUNTER=1, NUM_SLICE=1, Out_ready=0 for 5 cycles then 1 -> a single read, Out_valid held at index 0, and Done 1 cycle after the transfer.
